// File: rtl/pwm_soft_start_seq_if.sv
// Control/status bundle between the register file, the PWM counter and the soft-start sequencer.
// master drives the requests and duty settings; slave (the sequencer) returns duty/load/status.
interface pwm_soft_start_seq_if #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CNT_WIDTH = 3
);
  logic                 enable;
  logic                 ss_req;
  logic                 period_start;
  logic [WIDTH-1:0]     target_duty;
  logic [7:0]           duty_step;
  logic [CNT_WIDTH-1:0] periods_per_step;
  logic [WIDTH-1:0]     duty_out;
  logic                 load;
  logic                 busy;
  logic                 done;

  modport master (
    output enable, ss_req, period_start, target_duty, duty_step, periods_per_step,
    input  duty_out, load, busy, done
  );

  modport slave (
    input  enable, ss_req, period_start, target_duty, duty_step, periods_per_step,
    output duty_out, load, busy, done
  );
endinterface

// File: rtl/pwm_soft_start_seq.sv
// Soft-start sequencer: ramps a PWM channel's duty to its target in period-aligned steps, then
// passes programmed duty through, issuing shadow-load pulses only at safe points.
module pwm_soft_start_seq #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CNT_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pwm_soft_start_seq_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StRamp, StRun} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     duty_q, duty_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 load_q, load_d;
  logic                 done_q, done_d;

  logic [7:0]           step_eff;
  logic [WIDTH:0]       duty_sum;
  logic [WIDTH:0]       target_ext;
  logic [WIDTH-1:0]     duty_next;

  // One bit of headroom so the step add saturates at target instead of wrapping.
  always_comb begin
    step_eff   = (bus.duty_step == 8'd0) ? 8'd1 : bus.duty_step;
    duty_sum   = {1'b0, duty_q} + {{(WIDTH - 7){1'b0}}, step_eff};
    target_ext = {1'b0, bus.target_duty};
    duty_next  = (duty_sum > target_ext) ? bus.target_duty : duty_sum[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    cnt_d   = cnt_q;
    load_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.enable && bus.ss_req) begin
          state_d = StRamp;
          duty_d  = '0;
          cnt_d   = '0;
          load_d  = 1'b1;
        end
      end
      StRamp, StRun: begin
        if (!bus.enable) begin
          // Force-off is immediate, not period aligned.
          state_d = StIdle;
          duty_d  = '0;
          cnt_d   = '0;
          load_d  = 1'b1;
        end else if (bus.ss_req) begin
          state_d = StRamp;
          duty_d  = '0;
          cnt_d   = '0;
          load_d  = 1'b1;
        end else if (bus.period_start) begin
          if (state_q == StRamp) begin
            if (cnt_q == bus.periods_per_step) begin
              cnt_d  = '0;
              duty_d = duty_next;
              load_d = 1'b1;
              if (duty_next == bus.target_duty) begin
                state_d = StRun;
                done_d  = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else if (bus.target_duty != duty_q) begin
            duty_d = bus.target_duty;
            load_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        duty_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      duty_q  <= '0;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      done_q  <= done_d;
    end
  end

  assign bus.duty_out = duty_q;
  assign bus.load     = load_q;
  assign bus.busy     = (state_q == StRamp);
  assign bus.done     = done_q;

endmodule

// File: tb/tb_pwm_soft_start_seq.sv
// Bench for pwm_soft_start_seq: directed vector table, hand-written corner sequences and a
// randomized run checked against an arithmetic model of the soft-start rules.
module tb_pwm_soft_start_seq;
  localparam int W  = 16;
  localparam int CW = 3;

  logic clk;
  logic reset_n;

  pwm_soft_start_seq_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus ();

  pwm_soft_start_seq #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Level inputs held between cycles.
  bit rstn;
  bit en;
  int tgt;
  int stp;
  int pps;

  // Reference model: mode 0 = idle, 1 = ramping, 2 = running.
  int m_mode = 0;
  int m_duty = 0;
  int m_cnt  = 0;
  bit m_load = 0;
  bit m_done = 0;

  task automatic model_step(input bit r, input bit e, input bit s, input bit p,
                            input int t, input int st, input int pp);
    int inc;
    m_load = 0;
    m_done = 0;
    if (!r) begin
      m_mode = 0; m_duty = 0; m_cnt = 0;
    end else if (m_mode != 0 && !e) begin
      m_mode = 0; m_duty = 0; m_cnt = 0; m_load = 1;
    end else if (e && s) begin
      m_mode = 1; m_duty = 0; m_cnt = 0; m_load = 1;
    end else if (m_mode == 1 && p) begin
      if (m_cnt == pp) begin
        inc    = (st == 0) ? 1 : st;
        m_cnt  = 0;
        m_duty = (m_duty + inc > t) ? t : m_duty + inc;
        m_load = 1;
        if (m_duty == t) begin
          m_mode = 2;
          m_done = 1;
        end
      end else begin
        m_cnt = (m_cnt + 1) % (1 << CW);
      end
    end else if (m_mode == 2 && p && t != m_duty) begin
      m_duty = t;
      m_load = 1;
    end
  endtask

  task automatic cyc(input bit ss, input bit ps);
    reset_n              = rstn;
    bus.enable           = en;
    bus.ss_req           = ss;
    bus.period_start     = ps;
    bus.target_duty      = W'(tgt);
    bus.duty_step        = 8'(stp);
    bus.periods_per_step = CW'(pps);
    @(posedge clk);
    model_step(rstn, en, ss, ps, tgt, stp, pps);
    #1;
  endtask

  task automatic check(input string name, input int ed, input bit el, input bit eb,
                       input bit edn);
    n_tests++;
    if ({bus.duty_out, bus.load, bus.busy, bus.done} !== {W'(ed), el, eb, edn}) begin
      n_fail++;
      $display("FAIL %s: got duty=%0d load=%0b busy=%0b done=%0b, want duty=%0d load=%0b busy=%0b done=%0b",
               name, bus.duty_out, bus.load, bus.busy, bus.done, ed, el, eb, edn);
    end
  endtask

  task automatic check_model(input string name);
    check(name, m_duty, m_load, (m_mode == 1), m_done);
  endtask

  typedef struct {
    bit rstn; bit en; bit ss; bit ps;
    int tgt; int stp; int pps;
    int ed; bit el; bit eb; bit edn;
  } vec_t;

  vec_t vecs[11];

  initial begin
    // Reset, idle period_starts, then target 20 / step 5 / every period.
    vecs[0]  = '{0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0};
    vecs[2]  = '{1, 0, 0, 1,  0, 0, 0,   0, 0, 0, 0};
    vecs[3]  = '{1, 1, 0, 1, 20, 5, 0,   0, 0, 0, 0};
    vecs[4]  = '{1, 1, 1, 0, 20, 5, 0,   0, 1, 1, 0};
    vecs[5]  = '{1, 1, 0, 1, 20, 5, 0,   5, 1, 1, 0};
    vecs[6]  = '{1, 1, 0, 0, 20, 5, 0,   5, 0, 1, 0};
    vecs[7]  = '{1, 1, 0, 1, 20, 5, 0,  10, 1, 1, 0};
    vecs[8]  = '{1, 1, 0, 1, 20, 5, 0,  15, 1, 1, 0};
    vecs[9]  = '{1, 1, 0, 1, 20, 5, 0,  20, 1, 0, 1};
    vecs[10] = '{1, 1, 0, 1, 20, 5, 0,  20, 0, 0, 0};

    rstn = 0; en = 0; tgt = 0; stp = 0; pps = 0;

    for (int i = 0; i < 11; i++) begin
      rstn = vecs[i].rstn; en = vecs[i].en;
      tgt  = vecs[i].tgt;  stp = vecs[i].stp; pps = vecs[i].pps;
      cyc(vecs[i].ss, vecs[i].ps);
      check($sformatf("vec%0d", i), vecs[i].ed, vecs[i].el, vecs[i].eb, vecs[i].edn);
    end

    // Three periods per step, saturating at 10.
    rstn = 0; cyc(0, 0); cyc(0, 0);
    rstn = 1; en = 1; tgt = 10; stp = 4; pps = 2;
    cyc(1, 0);
    check("pps2_entry", 0, 1, 1, 0);
    for (int k = 1; k <= 9; k++) begin
      int ed;
      ed = (k / 3) * 4;
      if (ed > 10) ed = 10;
      cyc(0, 1);
      check($sformatf("pps2_ps%0d", k), ed, (k % 3 == 0), (k < 9), (k == 9));
      cyc(0, 0);
      check($sformatf("pps2_gap%0d", k), ed, 0, (k < 9), 0);
    end

    // RUN: lowered target applied only at the next period boundary.
    tgt = 8;
    cyc(0, 0); cyc(0, 0); cyc(0, 0);
    check("run_hold", 10, 0, 0, 0);
    cyc(0, 1);
    check("run_update", 8, 1, 0, 0);
    cyc(0, 1);
    check("run_nochange", 8, 0, 0, 0);

    // Disable mid-ramp, then ss_req while disabled.
    tgt = 20; stp = 4; pps = 0;
    cyc(1, 0);
    cyc(0, 1); cyc(0, 1);
    check("ramp_at8", 8, 1, 1, 0);
    en = 0;
    cyc(0, 0);
    check("disable_off", 0, 1, 0, 0);
    cyc(1, 0);
    check("ss_ignored", 0, 0, 0, 0);

    // Restart coincident with period_start does not count that period.
    en = 1; tgt = 100; stp = 10; pps = 1;
    cyc(1, 0);
    cyc(0, 1);
    check("restart_pre", 0, 0, 1, 0);
    cyc(1, 1);
    check("restart_hit", 0, 1, 1, 0);
    cyc(0, 1);
    check("restart_cnt1", 0, 0, 1, 0);
    cyc(0, 1);
    check("restart_step", 10, 1, 1, 0);

    // Reset mid-ramp: reset values, no load.
    rstn = 0;
    cyc(0, 0);
    check("midramp_reset", 0, 0, 0, 0);
    rstn = 1;
    cyc(0, 1);
    check("post_reset_idle", 0, 0, 0, 0);

    // Zero target completes on the first step.
    tgt = 0; stp = 5; pps = 0;
    cyc(1, 0);
    check("zero_tgt_entry", 0, 1, 1, 0);
    cyc(0, 1);
    check("zero_tgt_done", 0, 1, 0, 1);

    // ss_req together with disable: disable wins.
    tgt = 50;
    cyc(1, 0);
    cyc(0, 1);
    check("tgt50_step", 5, 1, 1, 0);
    en = 0;
    cyc(1, 0);
    check("ss_vs_disable", 0, 1, 0, 0);

    // Target lowered below the ramp clamps down and finishes.
    en = 1; tgt = 50; stp = 20;
    cyc(1, 0);
    cyc(0, 1); cyc(0, 1);
    check("clamp_pre", 40, 1, 1, 0);
    tgt = 30;
    cyc(0, 1);
    check("clamp_done", 30, 1, 0, 1);

    // Randomized run against the reference model.
    for (int c = 0; c < 4000; c++) begin
      bit ss;
      bit ps;
      rstn = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 59) == 0) en = ~en;
      if ($urandom_range(0, 49) == 0) tgt = $urandom_range(0, 400);
      if ($urandom_range(0, 29) == 0) stp = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 80);
      if ($urandom_range(0, 39) == 0) pps = $urandom_range(0, 7);
      ss = ($urandom_range(0, 39) == 0);
      ps = ($urandom_range(0, 2) == 0);
      cyc(ss, ps);
      check_model($sformatf("rand%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
